mri_execute_unit: RTL and testbench
===================================

Name: mri_execute_unit

Overview:
- Execute stage placed directly downstream of the fetch/decode framework.
- Consumes the decoded instruction at T3: opcode IR[14:12], indirect bit IR[15], 12-bit address IR[11:0] and the incremented PC.
- Performs the seven memory-reference instructions (AND, ADD, LDA, STA, BUN, BSA, ISZ), including indirect address resolution.
- Owns AC and E, drives the data-memory port, and hands a PC redirect plus a completion pulse back to the sequencer.

Parameters:
- WIDTH, 16, data word width of AC, DR and memory words.
- AW, 12, address width of memory and PC.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  instruction valid; accepted only when busy=0.
- opcode  in  3  IR[14:12].
- indirect  in  1  IR[15].
- addr  in  AW  IR[11:0].
- pc  in  AW  current (already incremented) PC.
- mem_rdata  in  WIDTH  read data, valid the cycle after mem_rd.
- mem_addr  out  AW  memory address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe; memory writes on the edge ending that cycle.
- mem_wdata  out  WIDTH  write data.
- ac  out  WIDTH  accumulator.
- e  out  1  carry flag.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_next  out  AW  redirect value.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, async): state=IDLE; ac, e, mem_addr, mem_wdata, pc_next all 0; mem_rd, mem_wr, pc_load, busy, done all 0.
- Reset mid-operation aborts the instruction. No write is issued after reset is released.
- IDLE: on start=1, capture opcode, addr (into AR), indirect and pc.
  - Next state is IND_RD if indirect=1, otherwise the opcode path.
  - opcode 7 (non-MRI) goes straight to DONE with no side effects.
- start while busy=1 is ignored.
- IND_RD: mem_rd=1, mem_addr=AR.
- IND_WT: AR<=mem_rdata[AW-1:0]. The effective address replaces AR.
- AND, ADD, LDA, ISZ paths:
  - RD: mem_rd=1, mem_addr=AR.
  - WT: DR<=mem_rdata.
  - EX:
    - AND: AC<=AC&DR.
    - ADD: {E,AC}<=AC+DR, a (WIDTH+1)-bit sum.
    - LDA: AC<=DR.
    - ISZ: DR<=DR+1, wrapping mod 2^WIDTH.
  - ISZ then WR: mem_wr=1, mem_addr=AR, mem_wdata=DR. If DR==0, pc_load=1 and pc_next=pc+1 (wrap mod 2^AW) in the same cycle.
- STA: WR with mem_wdata=AC.
- BUN: EX with pc_load=1, pc_next=AR.
- BSA: WR with mem_wdata={zeros,pc}, plus pc_load=1 and pc_next=AR+1 (wrap).
- DONE: done=1 for one cycle, then IDLE. busy drops in the DONE cycle.
- Latency from the acceptance edge to the done cycle (direct / indirect):
  - AND/ADD/LDA: 4 / 6.
  - ISZ: 5 / 7.
  - STA/BSA/BUN: 2 / 4.
  - opcode 7: 1.
- E changes only on ADD. AC is unchanged by STA, BUN, BSA and ISZ.
- mem_rd and mem_wr are never high together. Both are low in IDLE and DONE.

Optional Feature:
- Macro: MRI_AC_WRITE_EN.
- Enabled:
  - Adds inputs ac_wr (1), ac_wdata (WIDTH) and e_wdata (1) for the register-reference stage (CLA, CMA, CIR, etc.).
  - In IDLE, ac_wr=1 loads AC/E on that edge.
  - If start arrives in the same cycle, both take effect and the instruction operates on the new AC.
  - ac_wr is ignored while busy.
- Disabled: the ports are absent and AC/E are modified only by AND/ADD/LDA.

Decomposition:
- Shared package bascomp_pkg holds:
  - opcode constants OP_AND=0, OP_ADD=1, OP_LDA=2, OP_STA=3, OP_BUN=4, OP_BSA=5, OP_ISZ=6.
  - execute-state encodings.
  - default WIDTH/AW.
- One natural sub-module: mri_alu, combinational. Takes AC, DR and op; returns new AC, carry and the ISZ increment/zero flag.
- The FSM stays in the top module.

Test Plan:
- Direct ADD: AC=16'hFFFF, mem[12'h010]=16'h0002, opcode=1, addr=10 -> AC=16'h0001, E=1, done 4 cycles after acceptance, no mem_wr.
- Indirect LDA: mem[20]=16'h0030, mem[30]=16'hABCD, indirect=1, addr=20 -> reads at 20 then 30, AC=16'hABCD, done at cycle 6.
- ISZ wrap: mem[40]=16'hFFFF, pc=12'h101 -> write mem[40]=0 and pc_load=1 with pc_next=12'h102. Second case mem[40]=5 -> write 6, pc_load never high.
- BSA: pc=12'h055, addr=12'h200 -> mem[200]=16'h0055, pc_next=12'h201, done at cycle 2. BUN indirect via mem[300]=16'h0123 -> pc_next=12'h123.
- Reset mid-STA: assert reset=0 during the WR-preceding cycle -> mem_wr never rises, AC=0, busy=0. start while busy -> ignored, no second done.
- With MRI_AC_WRITE_EN: ac_wr=1, ac_wdata=16'h00F0 together with start of AND (mem=16'h0FF0) -> AC=16'h00F0.

Source files
------------

// File: rtl/bascomp_pkg.sv
// Shared definitions for the basic-computer execute stage: opcodes, execute-state
// encodings, default widths and the per-opcode entry state after address resolution.
package bascomp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 12;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_LDA  = 3'd2;
  localparam logic [2:0] OP_STA  = 3'd3;
  localparam logic [2:0] OP_BUN  = 3'd4;
  localparam logic [2:0] OP_BSA  = 3'd5;
  localparam logic [2:0] OP_ISZ  = 3'd6;
  localparam logic [2:0] OP_NMRI = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IND_RD,
    ST_IND_WT,
    ST_RD,
    ST_WT,
    ST_EX,
    ST_WR,
    ST_DONE
  } exec_state_e;

  // First state once the effective address is known.
  function automatic exec_state_e op_entry(input logic [2:0] op);
    case (op)
      OP_AND, OP_ADD, OP_LDA, OP_ISZ: op_entry = ST_RD;
      OP_STA, OP_BSA:                 op_entry = ST_WR;
      OP_BUN:                         op_entry = ST_EX;
      default:                        op_entry = ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/mri_execute_unit_alu.sv
// Combinational datapath for memory-reference instructions: AND/ADD/LDA result,
// ADD carry, and the ISZ increment with its zero flag.
module mri_alu
  import bascomp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] dr,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] ac_new,
  output logic             carry,
  output logic [WIDTH-1:0] dr_inc,
  output logic             dr_inc_zero
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum         = {1'b0, ac} + {1'b0, dr};
    carry       = sum[WIDTH];
    dr_inc      = dr + {{(WIDTH-1){1'b0}}, 1'b1};
    dr_inc_zero = (dr_inc == '0);
    case (op)
      OP_AND:  ac_new = ac & dr;
      OP_ADD:  ac_new = sum[WIDTH-1:0];
      OP_LDA:  ac_new = dr;
      default: ac_new = ac;
    endcase
  end

endmodule

// File: rtl/mri_execute_unit.sv
// Execute stage for the seven memory-reference instructions; owns AC/E and the data
// memory port. Optional MRI_AC_WRITE_EN adds an AC/E load port for register-reference ops.
module mri_execute_unit
  import bascomp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             indirect,
  input  logic [AW-1:0]    addr,
  input  logic [AW-1:0]    pc,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             pc_load,
  output logic [AW-1:0]    pc_next,
  output logic             busy,
  output logic             done
`ifdef MRI_AC_WRITE_EN
  ,
  input  logic             ac_wr,
  input  logic [WIDTH-1:0] ac_wdata,
  input  logic             e_wdata
`endif
);

  exec_state_e      state_q, state_d;
  logic [AW-1:0]    ar_q, ar_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             pc_load_q, pc_load_d;
  logic [AW-1:0]    pc_next_q, pc_next_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_ac;
  logic             alu_carry;
  logic [WIDTH-1:0] alu_dr_inc;
  logic             alu_dr_zero;

  mri_alu #(.WIDTH(WIDTH)) u_alu (
    .ac          (ac_q),
    .dr          (dr_q),
    .op          (op_q),
    .ac_new      (alu_ac),
    .carry       (alu_carry),
    .dr_inc      (alu_dr_inc),
    .dr_inc_zero (alu_dr_zero)
  );

  always_comb begin
    state_d     = state_q;
    ar_d        = ar_q;
    dr_d        = dr_q;
    op_d        = op_q;
    pc_d        = pc_q;
    ac_d        = ac_q;
    e_d         = e_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_next_d   = pc_next_q;

    case (state_q)
      ST_IDLE: begin
`ifdef MRI_AC_WRITE_EN
        if (ac_wr) begin
          ac_d = ac_wdata;
          e_d  = e_wdata;
        end
`endif
        if (start) begin
          op_d = opcode;
          ar_d = addr;
          pc_d = pc;
          if (opcode == OP_NMRI)  state_d = ST_DONE;
          else if (indirect)      state_d = ST_IND_RD;
          else                    state_d = op_entry(opcode);
        end
      end
      ST_IND_RD: state_d = ST_IND_WT;
      ST_IND_WT: begin
        ar_d    = mem_rdata[AW-1:0];
        state_d = op_entry(op_q);
      end
      ST_RD: state_d = ST_WT;
      ST_WT: begin
        dr_d    = mem_rdata;
        state_d = ST_EX;
      end
      ST_EX: begin
        if (op_q == OP_ISZ) begin
          dr_d    = alu_dr_inc;
          state_d = ST_WR;
        end else begin
          ac_d = alu_ac;
          if (op_q == OP_ADD) e_d = alu_carry;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the state being entered so they register cleanly.
    mem_rd_d  = (state_d == ST_IND_RD) || (state_d == ST_RD);
    mem_wr_d  = (state_d == ST_WR);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    pc_load_d = 1'b0;

    if (mem_rd_d) mem_addr_d = ar_d;

    if (mem_wr_d) begin
      mem_addr_d = ar_d;
      case (op_d)
        OP_STA: mem_wdata_d = ac_d;
        OP_BSA: begin
          mem_wdata_d = {{(WIDTH-AW){1'b0}}, pc_d};
          pc_load_d   = 1'b1;
          pc_next_d   = ar_d + {{(AW-1){1'b0}}, 1'b1};
        end
        default: begin
          mem_wdata_d = dr_d;
          if (alu_dr_zero) begin
            pc_load_d = 1'b1;
            pc_next_d = pc_d + {{(AW-1){1'b0}}, 1'b1};
          end
        end
      endcase
    end

    if ((state_d == ST_EX) && (op_d == OP_BUN)) begin
      pc_load_d = 1'b1;
      pc_next_d = ar_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ac_q        <= '0;
      e_q         <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      pc_load_q   <= 1'b0;
      pc_next_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ac_q        <= ac_d;
      e_q         <= e_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_load_q   <= pc_load_d;
      pc_next_q   <= pc_next_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Instruction operand registers are only consumed after acceptance.
  always_ff @(posedge clock) begin
    ar_q <= ar_d;
    dr_q <= dr_d;
    op_q <= op_d;
    pc_q <= pc_d;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign ac        = ac_q;
  assign e         = e_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mri_execute_unit.sv
// Scoreboard bench for mri_execute_unit: a transaction-level model predicts AC/E,
// latency, memory writes and PC redirects; a monitor checks them on each done pulse.
module tb_mri_execute_unit;
  import bascomp_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        indirect = 1'b0;
  logic [11:0] addr = 12'd0;
  logic [11:0] pc = 12'd0;
  logic [15:0] mem_rdata = 16'd0;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] ac;
  logic        e;
  logic        pc_load;
  logic [11:0] pc_next;
  logic        busy, done;
`ifdef MRI_AC_WRITE_EN
  logic        ac_wr = 1'b0;
  logic [15:0] ac_wdata = 16'd0;
  logic        e_wdata = 1'b0;
`endif

  mri_execute_unit #(.WIDTH(16), .AW(12)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .indirect  (indirect),
    .addr      (addr),
    .pc        (pc),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .ac        (ac),
    .e         (e),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .busy      (busy),
    .done      (done)
`ifdef MRI_AC_WRITE_EN
    ,
    .ac_wr     (ac_wr),
    .ac_wdata  (ac_wdata),
    .e_wdata   (e_wdata)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory: synchronous write, read data registered one cycle after mem_rd.
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'd0;
  logic [15:0] bd_data = 16'd0;

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [15:0] ac;
    logic        e;
    int          lat;
    int          nwr;
    logic [11:0] wa;
    logic [15:0] wd;
    int          npl;
    logic [11:0] pn;
    int          nrd;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_ac = 16'd0;
  logic        m_e = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Instruction-level reference: effective address, then the architectural effect.
  task automatic model(input logic [2:0] op, input logic ind, input logic [11:0] a,
                       input logic [11:0] p, output exp_t x);
    logic [11:0] ea;
    logic [16:0] s;
    logic [15:0] v;
    x.nwr = 0; x.npl = 0; x.wa = 12'd0; x.wd = 16'd0; x.pn = 12'd0;
    x.nrd = 0; x.acc = 0;
    ea = ind ? ref_mem[a][11:0] : a;
    if (op == 3'd7) x.lat = 1;
    else begin
      x.nrd = ind ? 1 : 0;
      case (op)
        3'd0: begin m_ac = m_ac & ref_mem[ea]; x.lat = 4; x.nrd += 1; end
        3'd1: begin
          s = {1'b0, m_ac} + {1'b0, ref_mem[ea]};
          m_ac = s[15:0]; m_e = s[16]; x.lat = 4; x.nrd += 1;
        end
        3'd2: begin m_ac = ref_mem[ea]; x.lat = 4; x.nrd += 1; end
        3'd3: begin
          ref_mem[ea] = m_ac; x.nwr = 1; x.wa = ea; x.wd = m_ac; x.lat = 2;
        end
        3'd4: begin x.npl = 1; x.pn = ea; x.lat = 2; end
        3'd5: begin
          ref_mem[ea] = {4'h0, p}; x.nwr = 1; x.wa = ea; x.wd = {4'h0, p};
          x.npl = 1; x.pn = ea + 12'd1; x.lat = 2;
        end
        default: begin
          v = ref_mem[ea] + 16'd1; ref_mem[ea] = v;
          x.nwr = 1; x.wa = ea; x.wd = v; x.nrd += 1; x.lat = 5;
          if (v == 16'd0) begin x.npl = 1; x.pn = p + 12'd1; end
        end
      endcase
      if (ind) x.lat += 2;
    end
    x.ac = m_ac;
    x.e  = m_e;
  endtask

  // Monitor
  int          wr_n = 0, pl_n = 0, rd_n = 0;
  logic [11:0] wa_o = 12'd0, pn_o = 12'd0;
  logic [15:0] wd_o = 16'd0;
  exp_t        mx;

  always @(negedge clock) begin
    if (!reset) begin
      wr_n = 0; pl_n = 0; rd_n = 0;
    end else begin
      if (mem_rd || mem_wr) chk("strobe_excl_busy", {30'd0, mem_rd & mem_wr, ~busy}, 32'd0);
      if (mem_wr) begin wr_n++; wa_o = mem_addr; wd_o = mem_wdata; end
      if (mem_rd) rd_n++;
      if (pc_load) begin pl_n++; pn_o = pc_next; end
      if (done) begin
        if (sbq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          mx = sbq.pop_front();
          chk("ac", {16'd0, ac}, {16'd0, mx.ac});
          chk("e", {31'd0, e}, {31'd0, mx.e});
          chk("latency", cyc - mx.acc, mx.lat);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          chk("wr_count", wr_n, mx.nwr);
          if (mx.nwr > 0) begin
            chk("wr_addr", {20'd0, wa_o}, {20'd0, mx.wa});
            chk("wr_data", {16'd0, wd_o}, {16'd0, mx.wd});
          end
          chk("pc_load_count", pl_n, mx.npl);
          if (mx.npl > 0) chk("pc_next", {20'd0, pn_o}, {20'd0, mx.pn});
          chk("rd_count", rd_n, mx.nrd);
        end
        wr_n = 0; pl_n = 0; rd_n = 0;
      end
    end
  end

  task automatic set_mem(input logic [11:0] a, input logic [15:0] d);
    @(negedge clock);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    ref_mem[a] = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic ind, input logic [11:0] a,
                       input logic [11:0] p, input bit push);
    exp_t x;
    @(negedge clock);
    opcode = op; indirect = ind; addr = a; pc = p; start = 1'b1;
`ifdef MRI_AC_WRITE_EN
    if (ac_wr) begin m_ac = ac_wdata; m_e = e_wdata; end
`endif
    if (push) begin
      model(op, ind, a, p, x);
      x.acc = cyc;
      sbq.push_back(x);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
`ifdef MRI_AC_WRITE_EN
    ac_wr = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sbq.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int wr_seen, done_seen, nm;
    bd_we = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      bd_addr = 12'(i);
      bd_data = 16'($urandom);
      ref_mem[i] = bd_data;
    end
    @(negedge clock);
    bd_we = 1'b0;

    chk("rst_ac", {16'd0, ac}, 32'd0);
    chk("rst_e", {31'd0, e}, 32'd0);
    chk("rst_ctrl", {27'd0, busy, done, mem_rd, mem_wr, pc_load}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_pc_next", {20'd0, pc_next}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    set_mem(12'h0A0, 16'hFFFF);
    issue(OP_LDA, 1'b0, 12'h0A0, 12'h000, 1'b1); wait_idle();
    set_mem(12'h010, 16'h0002);
    issue(OP_ADD, 1'b0, 12'h010, 12'h000, 1'b1); wait_idle();
    set_mem(12'h020, 16'h0030);
    set_mem(12'h030, 16'hABCD);
    issue(OP_LDA, 1'b1, 12'h020, 12'h000, 1'b1); wait_idle();
    set_mem(12'h040, 16'hFFFF);
    issue(OP_ISZ, 1'b0, 12'h040, 12'h101, 1'b1); wait_idle();
    set_mem(12'h040, 16'h0005);
    issue(OP_ISZ, 1'b0, 12'h040, 12'h101, 1'b1); wait_idle();
    issue(OP_BSA, 1'b0, 12'h200, 12'h055, 1'b1); wait_idle();
    set_mem(12'h300, 16'h0123);
    issue(OP_BUN, 1'b1, 12'h300, 12'h000, 1'b1); wait_idle();
    issue(OP_NMRI, 1'b1, 12'h123, 12'h000, 1'b1); wait_idle();

    // A second start while busy must be dropped.
    issue(OP_LDA, 1'b0, 12'h030, 12'h000, 1'b1);
    @(negedge clock);
    opcode = OP_STA; indirect = 1'b0; addr = 12'h050; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (6) @(negedge clock);

    // Reset while an indirect STA is resolving its address.
    set_mem(12'h0B0, 16'h00C0);
    issue(OP_STA, 1'b1, 12'h0B0, 12'h000, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wr_seen = 0; done_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (mem_wr) wr_seen++;
      if (done) done_seen++;
    end
    chk("mid_rst_ac", {16'd0, ac}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    m_ac = 16'd0; m_e = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (mem_wr) wr_seen++;
      if (done) done_seen++;
    end
    chk("mid_rst_no_write", wr_seen, 0);
    chk("mid_rst_no_done", done_seen, 0);

`ifdef MRI_AC_WRITE_EN
    set_mem(12'h0D0, 16'h0FF0);
    ac_wr = 1'b1; ac_wdata = 16'h00F0; e_wdata = 1'b1;
    issue(OP_AND, 1'b0, 12'h0D0, 12'h000, 1'b1); wait_idle();
`endif

    for (int k = 0; k < 200; k++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 12'($urandom),
            12'($urandom), 1'b1);
      wait_idle();
    end

    repeat (8) @(negedge clock);
    chk("queue_empty", sbq.size(), 0);
    nm = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nm++;
    chk("mem_image", nm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
